// File: rtl/rmw_port_arbiter.sv
// rmw_port_arbiter: round-robin sharing of a single-port memory for reads and atomic fetch-and-add
module rmw_port_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_wen,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_wen,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_t;
   state_t            state;
   logic              last_grant;
   logic              owner;
   logic              op_wen;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_wdata;
   logic [DATA_W-1:0] old_data;
   logic              g0;
   logic              g1;
   logic              rsp_v;
   logic [DATA_W-1:0] rsp_d;
   // grant decode; gated by rst_n so no ready is shown while reset is asserted
   always_comb begin
      g1    = rst_n && state == IDLE && req1_valid && (!req0_valid || !last_grant);
      g0    = rst_n && state == IDLE && req0_valid && !g1;
      rsp_v = (state == MODIFY && !op_wen) || state == WRITE;
      rsp_d = state == MODIFY ? mem_rdata : old_data;
   end
   assign req0_ready = g0;
   assign req1_ready = g1;
   assign rsp0_valid = rsp_v && !owner;
   assign rsp1_valid = rsp_v && owner;
   assign rsp0_rdata = rsp0_valid ? rsp_d : '0;
   assign rsp1_rdata = rsp1_valid ? rsp_d : '0;
   // access sequencer; memory strobes are registered one cycle ahead of the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_wen     <= 1'b0;
         op_addr    <= '0;
         op_wdata   <= '0;
         old_data   <= '0;
         mem_cen    <= 1'b0;
         mem_wen    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: if (g0 || g1) begin
               owner      <= g1;
               last_grant <= g1;
               op_wen     <= g1 ? req1_wen : req0_wen;
               op_addr    <= g1 ? req1_addr : req0_addr;
               op_wdata   <= g1 ? req1_wdata : req0_wdata;
               mem_cen    <= 1'b1;
               mem_wen    <= 1'b0;
               mem_addr   <= g1 ? req1_addr : req0_addr;
               state      <= READ;
            end
            READ: begin
               mem_cen  <= 1'b0;
               mem_addr <= '0;
               state    <= MODIFY;
            end
            MODIFY: begin
               old_data <= mem_rdata;
               if (op_wen) begin
                  mem_cen   <= 1'b1;
                  mem_wen   <= 1'b1;
                  mem_addr  <= op_addr;
                  mem_wdata <= mem_rdata + op_wdata;
                  state     <= WRITE;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               mem_cen   <= 1'b0;
               mem_wen   <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rmw_port_arbiter.sv
// tb_rmw_port_arbiter: directed self-checking bench with a behavioural memory
module tb_rmw_port_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req0_wen = 1'b0, req1_valid = 1'b0, req1_wen = 1'b0;
   logic [3:0] req0_addr = '0, req1_addr = '0;
   logic [7:0] req0_wdata = '0, req1_wdata = '0;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic       mem_cen, mem_wen;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = '0;
   logic [7:0] mem [16];
   int         checks = 0;
   int         errors = 0;

   rmw_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // single-port synchronous memory: read data one cycle after a read enable
   always @(posedge clk) begin
      if (mem_cen && mem_wen) mem[mem_addr] <= mem_wdata;
      if (mem_cen && !mem_wen) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[1] = 8'hA1;
      mem[2] = 8'hB2;
      mem[3] = 8'h11;
      mem[5] = 8'hF0;
      mem[7] = 8'h00;
      mem[9] = 8'h33;
      repeat (2) step;
      mid;
      chk("rst_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_cen, mem_wen}, 0);
      chk("rst_dat", {mem_addr, mem_wdata, rsp0_rdata, rsp1_rdata}, 0);
      step;
      rst_n = 1'b1;
      // plain read on port 0
      req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 4'h3;
      mid;
      chk("t1_rdy", {req0_ready, req1_ready}, 2'b10);
      step;
      req0_valid = 1'b0;
      mid;
      chk("t1_read", {mem_cen, mem_wen, mem_addr}, {1'b1, 1'b0, 4'h3});
      step;
      mid;
      chk("t1_rsp", {rsp0_valid, rsp0_rdata, rsp1_valid}, {1'b1, 8'h11, 1'b0});
      step;
      mid;
      chk("t1_done", {mem_cen, rsp0_valid, req0_ready}, 0);
      // RMW on port 1 with wrap-around
      step;
      req1_valid = 1'b1; req1_wen = 1'b1; req1_addr = 4'h5; req1_wdata = 8'h20;
      mid;
      chk("t2_rdy", {req0_ready, req1_ready}, 2'b01);
      step;
      req1_valid = 1'b0;
      mid;
      chk("t2_read", {mem_cen, mem_wen, mem_addr}, {1'b1, 1'b0, 4'h5});
      step;
      mid;
      chk("t2_mod", {mem_cen, rsp1_valid, rsp0_valid}, 0);
      step;
      mid;
      chk("t2_write", {mem_cen, mem_wen, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h5, 8'h10});
      chk("t2_rsp", {rsp1_valid, rsp1_rdata, rsp0_valid}, {1'b1, 8'hF0, 1'b0});
      step;
      mid;
      chk("t2_mem", mem[5], 8'h10);
      chk("t2_idle", {mem_cen, rsp1_valid}, 0);
      // both ports hold reads from reset: alternate 0,1,0,1 every 3 cycles
      step;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 4'h1;
      req1_valid = 1'b1; req1_wen = 1'b0; req1_addr = 4'h2;
      for (int k = 0; k < 4; k++) begin
         mid;
         chk("t3_rdy", {req0_ready, req1_ready}, k[0] ? 2'b01 : 2'b10);
         step;
         mid;
         chk("t3_read", {req0_ready, req1_ready, mem_cen, mem_addr}, {2'b00, 1'b1, k[0] ? 4'h2 : 4'h1});
         step;
         mid;
         chk("t3_rspv", {rsp0_valid, rsp1_valid}, k[0] ? 2'b01 : 2'b10);
         chk("t3_rspd", k[0] ? rsp1_rdata : rsp0_rdata, k[0] ? 8'hB2 : 8'hA1);
         step;
      end
      // both ports increment mem[7]; port 0 first, port 1 sees its write
      req0_wen = 1'b1; req0_addr = 4'h7; req0_wdata = 8'h01;
      req1_wen = 1'b1; req1_addr = 4'h7; req1_wdata = 8'h01;
      mid;
      chk("t4_rdy0", {req0_ready, req1_ready}, 2'b10);
      step;
      req0_valid = 1'b0;
      step;
      step;
      mid;
      chk("t4_rsp0", {rsp0_valid, rsp0_rdata, rsp1_valid}, {1'b1, 8'h00, 1'b0});
      chk("t4_wr0", {mem_cen, mem_wen, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h7, 8'h01});
      step;
      mid;
      chk("t4_rdy1", {req0_ready, req1_ready}, 2'b01);
      step;
      req1_valid = 1'b0;
      step;
      step;
      mid;
      chk("t4_rsp1", {rsp1_valid, rsp1_rdata, rsp0_valid}, {1'b1, 8'h01, 1'b0});
      chk("t4_wr1", mem_wdata, 8'h02);
      step;
      mid;
      chk("t4_mem", mem[7], 8'h02);
      // reset during the read of a port 1 RMW
      step;
      req1_valid = 1'b1; req1_wen = 1'b1; req1_addr = 4'h9; req1_wdata = 8'h05;
      mid;
      chk("t5_rdy", {req0_ready, req1_ready}, 2'b01);
      step;
      req1_valid = 1'b0;
      mid;
      chk("t5_read", {mem_cen, mem_addr}, {1'b1, 4'h9});
      #1;
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_wen = 1'b0;
      req1_valid = 1'b1; req1_wen = 1'b0;
      #1;
      chk("t5_abort", {req0_ready, req1_ready, mem_cen, mem_wen, rsp0_valid, rsp1_valid}, 0);
      step;
      step;
      rst_n = 1'b1;
      mid;
      chk("t5_rdy_after", {req0_ready, req1_ready}, 2'b10);
      step;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) step;
      chk("t5_nowrite", mem[9], 8'h33);
      // long idle stretch
      for (int i = 0; i < 20; i++) begin
         mid;
         chk("t6_idle", {mem_cen, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
         step;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
